// File: rtl/trap_ctrl_if.sv
// Shared word-width package and the pipeline/CSR-side bundle for trap_ctrl.
// The master modport is the pipeline and CSR side; the slave modport is the sequencer.
`timescale 1ns/1ps

package common_types_pkg;
   localparam int unsigned WORD_W = 32;
endpackage

interface trap_ctrl_if;
   import common_types_pkg::*;

   logic              exc_req;
   logic [WORD_W-1:0] exc_cause;
   logic [WORD_W-1:0] exc_pc;
   logic              irq_ext;
   logic              irq_sw;
   logic              irq_timer;
   logic [WORD_W-1:0] int_pc;
   logic              mret_req;
   logic [WORD_W-1:0] csr_mepc;
   logic              csr_mie;
   logic [1:0]        csr_mtvec_mode;
   logic [29:0]       csr_mtvec_base;
   logic              csr_exception;
   logic [WORD_W-1:0] csr_exception_cause;
   logic [WORD_W-1:0] csr_exception_pc;
   logic              busy;
   logic              flush;
   logic              redirect_valid;
   logic [WORD_W-1:0] redirect_pc;

   modport master (
      output exc_req, exc_cause, exc_pc, irq_ext, irq_sw, irq_timer, int_pc,
             mret_req, csr_mepc, csr_mie, csr_mtvec_mode, csr_mtvec_base,
      input  csr_exception, csr_exception_cause, csr_exception_pc, busy,
             flush, redirect_valid, redirect_pc
   );

   modport slave (
      input  exc_req, exc_cause, exc_pc, irq_ext, irq_sw, irq_timer, int_pc,
             mret_req, csr_mepc, csr_mie, csr_mtvec_mode, csr_mtvec_base,
      output csr_exception, csr_exception_cause, csr_exception_pc, busy,
             flush, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, mret and interrupts, then
// overrides the CSR file for one cycle and redirects the pipeline. Macro: TRAP_VECTORED_EN.
`timescale 1ns/1ps

//  state      | meaning
//  S_IDLE     | waiting for exc_req / mret_req / enabled interrupt
//  S_COMMIT   | csr_exception strobe, trap target computed from mtvec
//  S_REDIRECT | flush + redirect to trap target
//  S_MRET     | flush + redirect to saved mepc
module trap_ctrl
   import common_types_pkg::*;
(
   input  logic       CLK,
   input  logic       nRST,
   trap_ctrl_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_REDIRECT, S_MRET} state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] cause_q, cause_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] target_q, target_d;
   logic              busy_q, busy_d;
   logic              irq_any;
   logic [WORD_W-1:0] direct_tgt;
   logic [WORD_W-1:0] trap_tgt;
   logic              unused_cause_msb;

   assign irq_any          = bus.irq_ext | bus.irq_sw | bus.irq_timer;
   assign direct_tgt       = {bus.csr_mtvec_base, 2'b00};
   assign unused_cause_msb = bus.exc_cause[WORD_W-1];

`ifdef TRAP_VECTORED_EN
   logic [WORD_W-1:0] vec_off;

   // Only interrupts vector; exceptions carry cause[31]=0 and fall through to direct.
   assign vec_off  = {cause_q[WORD_W-3:0], 2'b00};
   assign trap_tgt = (bus.csr_mtvec_mode == 2'b01 && cause_q[WORD_W-1])
                     ? direct_tgt + vec_off : direct_tgt;
`else
   logic unused_mtvec_mode;

   assign unused_mtvec_mode = ^bus.csr_mtvec_mode;
   assign trap_tgt          = direct_tgt;
`endif

   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      pc_d     = pc_q;
      target_d = target_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.exc_req) begin
               cause_d = {1'b0, bus.exc_cause[WORD_W-2:0]};
               pc_d    = bus.exc_pc;
               state_d = S_COMMIT;
            end else if (bus.mret_req) begin
               target_d = bus.csr_mepc;
               state_d  = S_MRET;
            end else if (bus.csr_mie && irq_any) begin
               cause_d = bus.irq_ext ? 32'h8000_000B :
                         bus.irq_sw  ? 32'h8000_0003 : 32'h8000_0007;
               pc_d    = bus.int_pc;
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            target_d = trap_tgt;
            state_d  = S_REDIRECT;
         end
         S_REDIRECT: state_d = S_IDLE;
         S_MRET:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= S_IDLE;
         cause_q  <= '0;
         pc_q     <= '0;
         target_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.csr_exception       = (state_q == S_COMMIT);
   assign bus.csr_exception_cause = cause_q;
   assign bus.csr_exception_pc    = pc_q;
   assign bus.busy                = busy_q;
   assign bus.redirect_valid      = (state_q == S_REDIRECT) || (state_q == S_MRET);
   assign bus.flush               = bus.redirect_valid;
   assign bus.redirect_pc         = bus.redirect_valid ? target_q : '0;

endmodule
